set_assoc_data_cache: RTL

SET_ASSOC_DATA_CACHE -- requirements
Module: set_assoc_data_cache

---
 rtl/set_assoc_data_cache.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_data_cache.sv
// set_assoc_data_cache
//   Write-back, write-allocate, set-associative data cache with LRU replacement
//   for a 32-bit RISC-V style core.
//
//   CPU side : clock, reset (async, active-high), read, write, address, writedata,
//              funct3 (load/store width), readdata, busywait (stall).
//   Memory   : mem_read, mem_write, mem_address (block address), mem_writedata,
//              mem_readdata, mem_busywait (low completes the request).
//   Debug    : debug_state (current FSM state).
//
//   Handshake: the CPU raises read/write and must hold address/data/funct3 stable
//   while busywait=1; the access completes at the rising edge where busywait=0.
//   Memory requests stay asserted until the rising edge where mem_busywait=0.
module set_assoc_data_cache #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          read,
  input  logic                          write,
  input  logic [31:0]                   address,
  input  logic [31:0]                   writedata,
  input  logic [2:0]                    funct3,
  output logic [31:0]                   readdata,
  output logic                          busywait,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [31-($clog2(WORDS)+2):0] mem_address,
  output logic [32*WORDS-1:0]           mem_writedata,
  input  logic [32*WORDS-1:0]           mem_readdata,
  input  logic                          mem_busywait,
  output logic [1:0]                    debug_state
);

  localparam int OFF = $clog2(WORDS) + 2;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - IDX - OFF;
  localparam int BLK = 32 * WORDS;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WSW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [BLK-1:0]  data_arr  [SETS][WAYS];
  logic [TAG-1:0]  tag_arr   [SETS][WAYS];
  logic [WW-1:0]   age_arr   [SETS][WAYS];
  logic [WAYS-1:0] valid_arr [SETS];
  logic [WAYS-1:0] dirty_arr [SETS];

  logic [1:0]      state;
  logic [WW-1:0]   victim_l;
  logic [IDX-1:0]  idx_l;
  logic [TAG-1:0]  tag_l;
  logic [TAG-1:0]  vtag_l;

  logic [TAG-1:0]  tag_in;
  logic [IDX-1:0]  idx;
  logic [WSW-1:0]  word_sel;
  logic [1:0]      byte_sel;
  logic            access;
  logic            hit;
  logic [WW-1:0]   hit_way;
  logic [BLK-1:0]  hit_block;
  logic [31:0]     hit_word;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [31:0]     merged_word;
  logic [BLK-1:0]  merged_block;
  logic [WW-1:0]   victim;
  logic            found;
  logic [WW-1:0]   max_age;
  logic [WW-1:0]   fill_old;

  assign tag_in   = address[31:IDX+OFF];
  assign idx      = address[IDX+OFF-1:OFF];
  // Masking keeps this legal when WORDS=1 and the word field is empty.
  assign word_sel = WSW'(address[31:2] & 30'(WORDS - 1));
  assign byte_sel = address[1:0];
  // Read and write together behave as a write.
  assign access   = read | write;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[idx][w] && tag_arr[idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  assign hit_block = data_arr[idx][hit_way];
  assign hit_word  = hit_block[word_sel*32 +: 32];
  assign busywait  = (access & ~hit) | (state != IDLE);

  always_comb begin
    lane_b = hit_word[byte_sel*8 +: 8];
    lane_h = byte_sel[1] ? hit_word[31:16] : hit_word[15:0];
    case (funct3)
      3'b000:  readdata = {{24{lane_b[7]}}, lane_b};
      3'b001:  readdata = {{16{lane_h[15]}}, lane_h};
      3'b100:  readdata = {24'b0, lane_b};
      3'b101:  readdata = {16'b0, lane_h};
      default: readdata = hit_word;
    endcase
  end

  always_comb begin
    merged_word = hit_word;
    case (funct3)
      3'b000: merged_word[byte_sel*8 +: 8] = writedata[7:0];
      3'b001: begin
        if (byte_sel[1]) merged_word[31:16] = writedata[15:0];
        else             merged_word[15:0]  = writedata[15:0];
      end
      default: merged_word = writedata;
    endcase
    merged_block = hit_block;
    merged_block[word_sel*32 +: 32] = merged_word;
  end

  // Lowest invalid way first, otherwise the oldest way.
  always_comb begin
    victim  = '0;
    found   = 1'b0;
    max_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_arr[idx][w] && !found) begin
        victim = WW'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_arr[idx][w] > max_age) begin
          max_age = age_arr[idx][w];
          victim  = WW'(w);
        end
      end
    end
  end

  // An invalid way is treated as the oldest, so filling it ages every other
  // way and the ages of a full set always form a permutation (true LRU).
  assign fill_old = valid_arr[idx_l][victim_l] ? age_arr[idx_l][victim_l] : WW'(WAYS - 1);

  function automatic logic [WW-1:0] aged(input logic [WW-1:0] cur, input logic is_acc,
                                         input logic [WW-1:0] old);
    if (is_acc)     return '0;
    if (cur < old)  return cur + WW'(1);
    return cur;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      victim_l  <= '0;
      idx_l     <= '0;
      tag_l     <= '0;
      vtag_l    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_arr[s][w] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (access && hit) begin
            if (write) dirty_arr[idx][hit_way] <= 1'b1;
            if (WAYS > 1)
              for (int w = 0; w < WAYS; w++)
                age_arr[idx][w] <= aged(age_arr[idx][w], WW'(w) == hit_way, age_arr[idx][hit_way]);
          end else if (access) begin
            // Victim and addresses are frozen here for the whole miss.
            victim_l <= victim;
            idx_l    <= idx;
            tag_l    <= tag_in;
            vtag_l   <= tag_arr[idx][victim];
            if (valid_arr[idx][victim] && dirty_arr[idx][victim]) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
            end else begin
              state    <= ALLOCATE;
              mem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state     <= ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (!mem_busywait) begin
            valid_arr[idx_l][victim_l] <= 1'b1;
            dirty_arr[idx_l][victim_l] <= 1'b0;
            if (WAYS > 1)
              for (int w = 0; w < WAYS; w++)
                age_arr[idx_l][w] <= aged(age_arr[idx_l][w], WW'(w) == victim_l, fill_old);
            state    <= IDLE;
            mem_read <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Data and tag storage carries no reset; validity alone qualifies it.
  always_ff @(posedge clock) begin
    if (state == IDLE && write && hit)
      data_arr[idx][hit_way] <= merged_block;
    if (state == ALLOCATE && !mem_busywait) begin
      data_arr[idx_l][victim_l] <= mem_readdata;
      tag_arr[idx_l][victim_l]  <= tag_l;
    end
  end

  assign mem_address   = (state == WRITEBACK) ? {vtag_l, idx_l} : {tag_l, idx_l};
  assign mem_writedata = data_arr[idx_l][victim_l];
  assign debug_state   = state;

endmodule
